// File: rtl/fp_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_game_pkg
//  Description : Shared round-state, winner-code and BCD tally definitions
//                for the two-player game score path.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_game_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAY       = 2'd1,
        ROUND_OVER = 2'd2
    } round_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Two-digit BCD increment; 99 is sticky so the display never wraps to 00.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v.tens == 4'd9 && v.ones == 4'd9) begin
            r = v;
        end else if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tick_sync
//  Description : Two-flop synchroniser for an asynchronous level followed by
//                a registered rising-edge detector. Emits a one-clock pulse
//                three clocks after the input rises.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Synchronise, keep one bit of history, and register the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Round state machine (IDLE / PLAY / ROUND_OVER) for the
//                two-player game. Tracks lives with per-player
//                invulnerability windows, keeps saturating BCD win tallies,
//                and drives the hex digit bus, life outputs and freeze flag.
//  Revision    : 1.0  initial release
// ============================================================================
module score_keeper
    import fp_game_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int OVER_FRAMES   = 180
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        player_1_hit,
    input  logic        player_2_hit,
    output logic [3:0]  p1_lives,
    output logic [3:0]  p2_lives,
    output logic [15:0] hex_digits,
    output logic        freeze,
    output logic [1:0]  winner,
    output logic        round_over
);

    localparam logic [3:0] c_start_lives = 4'(START_LIVES);
    localparam logic [7:0] c_invuln      = 8'(INVULN_FRAMES);
    localparam logic [9:0] c_over        = 10'(OVER_FRAMES);

    logic         w_tick;
    logic         w_start_edge;

    round_state_t r_state,        w_state_n;
    logic         r_start_pend,   w_start_pend_n;
    logic [3:0]   r_p1_lives,     w_p1_lives_n;
    logic [3:0]   r_p2_lives,     w_p2_lives_n;
    logic [7:0]   r_p1_inv,       w_p1_inv_n;
    logic [7:0]   r_p2_inv,       w_p2_inv_n;
    logic [9:0]   r_over_cnt,     w_over_n;
    bcd2_t        r_p1_tally,     w_p1_tally_n;
    bcd2_t        r_p2_tally,     w_p2_tally_n;
    logic [1:0]   r_winner,       w_winner_n;
    logic         r_freeze,       w_freeze_n;
    logic         r_round_over,   w_round_over_n;

    frame_tick_sync u_frame_sync (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_async (frame_clk),
        .o_pulse (w_tick)
    );

    frame_tick_sync u_start_sync (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_async (start),
        .o_pulse (w_start_edge)
    );

    // Next-state and next-output logic; everything advances only on a frame tick
    always_comb begin
        w_state_n      = r_state;
        w_start_pend_n = r_start_pend;
        w_p1_lives_n   = r_p1_lives;
        w_p2_lives_n   = r_p2_lives;
        w_p1_inv_n     = r_p1_inv;
        w_p2_inv_n     = r_p2_inv;
        w_over_n       = r_over_cnt;
        w_p1_tally_n   = r_p1_tally;
        w_p2_tally_n   = r_p2_tally;
        w_winner_n     = r_winner;
        w_freeze_n     = r_freeze;
        w_round_over_n = r_round_over;

        case (r_state)
            IDLE: begin
                // The start pulse is one clock wide, so hold it until the next tick
                if (w_start_edge) begin
                    w_start_pend_n = 1'b1;
                end
                if (w_tick && (r_start_pend || w_start_edge)) begin
                    w_start_pend_n = 1'b0;
                    w_p1_lives_n   = c_start_lives;
                    w_p2_lives_n   = c_start_lives;
                    w_p1_inv_n     = '0;
                    w_p2_inv_n     = '0;
                    w_freeze_n     = 1'b0;
                    w_state_n      = PLAY;
                end
            end

            PLAY: begin
                w_start_pend_n = 1'b0;
                if (w_tick) begin
                    // A running invulnerability window swallows the hit
                    if (r_p1_inv != '0) begin
                        w_p1_inv_n = r_p1_inv - 8'd1;
                    end else if (player_1_hit) begin
                        w_p1_inv_n = c_invuln;
                        if (r_p1_lives != '0) begin
                            w_p1_lives_n = r_p1_lives - 4'd1;
                        end
                    end

                    if (r_p2_inv != '0) begin
                        w_p2_inv_n = r_p2_inv - 8'd1;
                    end else if (player_2_hit) begin
                        w_p2_inv_n = c_invuln;
                        if (r_p2_lives != '0) begin
                            w_p2_lives_n = r_p2_lives - 4'd1;
                        end
                    end

                    // Round end is judged on the post-decrement lives
                    if (w_p1_lives_n == '0 || w_p2_lives_n == '0) begin
                        w_state_n      = ROUND_OVER;
                        w_freeze_n     = 1'b1;
                        w_round_over_n = 1'b1;
                        w_over_n       = c_over;
                        if (w_p1_lives_n == '0 && w_p2_lives_n == '0) begin
                            w_winner_n = WIN_DRAW;
                        end else if (w_p1_lives_n == '0) begin
                            w_winner_n   = WIN_P2;
                            w_p2_tally_n = bcd2_inc(r_p2_tally);
                        end else begin
                            w_winner_n   = WIN_P1;
                            w_p1_tally_n = bcd2_inc(r_p1_tally);
                        end
                    end
                end
            end

            ROUND_OVER: begin
                // Start presses here are dropped, not deferred
                w_start_pend_n = 1'b0;
                if (w_tick) begin
                    w_over_n = r_over_cnt - 10'd1;
                    if (w_over_n == '0) begin
                        w_state_n      = IDLE;
                        w_winner_n     = WIN_NONE;
                        w_round_over_n = 1'b0;
                        w_freeze_n     = 1'b1;
                    end
                end
            end

            default: begin
                w_state_n      = IDLE;
                w_start_pend_n = 1'b0;
                w_winner_n     = WIN_NONE;
                w_freeze_n     = 1'b1;
                w_round_over_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any round in progress
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_start_pend <= 1'b0;
            r_p1_lives   <= c_start_lives;
            r_p2_lives   <= c_start_lives;
            r_p1_inv     <= '0;
            r_p2_inv     <= '0;
            r_over_cnt   <= '0;
            r_p1_tally   <= '0;
            r_p2_tally   <= '0;
            r_winner     <= WIN_NONE;
            r_freeze     <= 1'b1;
            r_round_over <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_start_pend <= w_start_pend_n;
            r_p1_lives   <= w_p1_lives_n;
            r_p2_lives   <= w_p2_lives_n;
            r_p1_inv     <= w_p1_inv_n;
            r_p2_inv     <= w_p2_inv_n;
            r_over_cnt   <= w_over_n;
            r_p1_tally   <= w_p1_tally_n;
            r_p2_tally   <= w_p2_tally_n;
            r_winner     <= w_winner_n;
            r_freeze     <= w_freeze_n;
            r_round_over <= w_round_over_n;
        end
    end

    // Nibble order matches the SoC hex bus: P1 tens, P1 ones, P2 tens, P2 ones
    assign hex_digits = {r_p1_tally.tens, r_p1_tally.ones, r_p2_tally.tens, r_p2_tally.ones};
    assign p1_lives   = r_p1_lives;
    assign p2_lives   = r_p2_lives;
    assign freeze     = r_freeze;
    assign winner     = r_winner;
    assign round_over = r_round_over;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper. Instance A uses the
//                default parameters; instance B uses tiny lives/timer values
//                so many rounds fit in a short run. Both are compared against
//                a frame-level behavioural model of the round rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_keeper;

    localparam int A_LIVES = 3, A_INV = 60, A_OVER = 180;
    localparam int B_LIVES = 1, B_INV = 2,  B_OVER = 3;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        start_a = 1'b0, h1_a = 1'b0, h2_a = 1'b0;
    logic        start_b = 1'b0, h1_b = 1'b0, h2_b = 1'b0;
    logic [3:0]  p1_a, p2_a, p1_b, p2_b;
    logic [15:0] hex_a, hex_b;
    logic        frz_a, frz_b, ro_a, ro_b;
    logic [1:0]  win_a, win_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = waiting, 1 = in play, 2 = showing result
    int m_st[2], m_l1[2], m_l2[2], m_i1[2], m_i2[2], m_ov[2], m_w[2], m_t1[2], m_t2[2];
    bit m_pend[2];

    score_keeper dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start_a),
        .player_1_hit(h1_a), .player_2_hit(h2_a), .p1_lives(p1_a), .p2_lives(p2_a),
        .hex_digits(hex_a), .freeze(frz_a), .winner(win_a), .round_over(ro_a)
    );

    score_keeper #(.START_LIVES(B_LIVES), .INVULN_FRAMES(B_INV), .OVER_FRAMES(B_OVER)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start_b),
        .player_1_hit(h1_b), .player_2_hit(h2_b), .p1_lives(p1_b), .p2_lives(p2_b),
        .hex_digits(hex_b), .freeze(frz_b), .winner(win_b), .round_over(ro_b)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_pend[k] = 0;
            m_l1[k] = (k == 0) ? A_LIVES : B_LIVES;
            m_l2[k] = m_l1[k];
            m_i1[k] = 0; m_i2[k] = 0; m_ov[k] = 0; m_w[k] = 0;
            m_t1[k] = 0; m_t2[k] = 0;
        end
    endtask

    // One frame of the round rules applied to model k
    task automatic m_step(input int k, input bit h1, input bit h2);
        int lv, iv, ov;
        lv = (k == 0) ? A_LIVES : B_LIVES;
        iv = (k == 0) ? A_INV   : B_INV;
        ov = (k == 0) ? A_OVER  : B_OVER;
        if (m_st[k] == 0) begin
            if (m_pend[k]) begin
                m_pend[k] = 0; m_l1[k] = lv; m_l2[k] = lv;
                m_i1[k] = 0; m_i2[k] = 0; m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            if (m_i1[k] > 0) m_i1[k] = m_i1[k] - 1;
            else if (h1) begin m_i1[k] = iv; if (m_l1[k] > 0) m_l1[k] = m_l1[k] - 1; end
            if (m_i2[k] > 0) m_i2[k] = m_i2[k] - 1;
            else if (h2) begin m_i2[k] = iv; if (m_l2[k] > 0) m_l2[k] = m_l2[k] - 1; end
            if (m_l1[k] == 0 && m_l2[k] == 0) m_w[k] = 3;
            else if (m_l1[k] == 0) begin m_w[k] = 2; if (m_t2[k] < 99) m_t2[k] = m_t2[k] + 1; end
            else if (m_l2[k] == 0) begin m_w[k] = 1; if (m_t1[k] < 99) m_t1[k] = m_t1[k] + 1; end
            if (m_l1[k] == 0 || m_l2[k] == 0) begin m_st[k] = 2; m_ov[k] = ov; end
        end else begin
            m_ov[k] = m_ov[k] - 1;
            if (m_ov[k] == 0) begin m_st[k] = 0; m_w[k] = 0; end
        end
    endtask

    function automatic logic [27:0] exp_vec(input int k);
        logic [15:0] hx;
        hx = {4'(m_t1[k] / 10), 4'(m_t1[k] % 10), 4'(m_t2[k] / 10), 4'(m_t2[k] % 10)};
        return {4'(m_l1[k]), 4'(m_l2[k]), hx, 1'(m_st[k] != 1), 2'(m_w[k]), 1'(m_st[k] == 2)};
    endfunction

    function automatic logic [27:0] obs_vec(input int k);
        if (k == 0) return {p1_a, p2_a, hex_a, frz_a, win_a, ro_a};
        return {p1_b, p2_b, hex_b, frz_b, win_b, ro_b};
    endfunction

    // Drive one frame: inputs change, VS rises, tick propagates, VS falls
    task automatic frame(input logic sa, h1a, h2a, sb, h1b, h2b);
        @(negedge Clk);
        if (sa && !start_a && m_st[0] == 0) m_pend[0] = 1;
        if (sb && !start_b && m_st[1] == 0) m_pend[1] = 1;
        start_a = sa; h1_a = h1a; h2_a = h2a;
        start_b = sb; h1_b = h1b; h2_b = h2b;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        m_step(0, h1a, h2a);
        m_step(1, h1b, h2b);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
            end
        end
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_start();
        frame(1, 0, 0, 0, 0, 0);
        n_checks++;
        if ({p1_a, p2_a, hex_a, frz_a, ro_a} !== {4'd3, 4'd3, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL start: got lives %0d/%0d hex %h frz %b ro %b, expected 3/3 0000 0 0",
                     p1_a, p2_a, hex_a, frz_a, ro_a);
        end
    endtask

    task automatic test_hold_hit();
        frame(0, 1, 0, 0, 0, 0);
        n_checks++;
        if (p1_a !== 4'd2) begin
            n_fail++;
            $display("FAIL first_hit: got p1_lives %0d expected 2", p1_a);
        end
        for (int i = 1; i <= 61; i++) begin
            frame(0, 1, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL hold_hit frame %0d: got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
        end
        n_checks++;
        if (p1_a !== 4'd1) begin
            n_fail++;
            $display("FAIL hold_hit_second_loss: got p1_lives %0d expected 1", p1_a);
        end
        frame(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_p2_out();
        for (int h = 0; h < 3; h++) begin
            frame(0, 0, 1, 0, 0, 0);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL p2_hit %0d: got %h expected %h", h, obs_vec(0), exp_vec(0));
            end
            if (h < 2) repeat (61) frame(0, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if ({p2_a, win_a, ro_a, frz_a, hex_a} !== {4'd0, 2'b01, 1'b1, 1'b1, 16'h0100}) begin
            n_fail++;
            $display("FAIL p1_wins: got p2 %0d win %b ro %b frz %b hex %h, expected 0 01 1 1 0100",
                     p2_a, win_a, ro_a, frz_a, hex_a);
        end
        // Start pressed and held through the whole result display
        for (int i = 1; i <= 183; i++) begin
            frame(1, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL over_hold frame %0d: got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
            if (i == 180) begin
                n_checks++;
                if ({win_a, ro_a, frz_a} !== {2'b00, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL back_to_idle: got win %b ro %b frz %b expected 00 0 1", win_a, ro_a, frz_a);
                end
            end
        end
        n_checks++;
        if (frz_a !== 1'b1) begin
            n_fail++;
            $display("FAIL held_start_ignored: got freeze %b expected 1", frz_a);
        end
    endtask

    task automatic test_draw();
        frame(0, 0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0);
        for (int h = 0; h < 3; h++) begin
            frame(1, 1, 1, 0, 0, 0);
            if (h < 2) repeat (61) frame(1, 0, 0, 0, 0, 0);
        end
        n_checks++;
        if ({p1_a, p2_a, win_a, hex_a} !== {4'd0, 4'd0, 2'b11, 16'h0100}) begin
            n_fail++;
            $display("FAIL draw: got lives %0d/%0d win %b hex %h, expected 0/0 11 0100",
                     p1_a, p2_a, win_a, hex_a);
        end
        for (int i = 1; i <= 180; i++) begin
            frame(1, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec(0) !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL draw_over frame %0d: got %h expected %h", i, obs_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_async_reset();
        frame(0, 0, 0, 0, 0, 0);
        frame(1, 0, 0, 0, 0, 0);
        frame(1, 1, 0, 0, 0, 0);
        n_checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL pre_reset_play: got %h expected %h", obs_vec(0), exp_vec(0));
        end
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({p1_a, p2_a, hex_a, frz_a, win_a, ro_a} !== {4'd3, 4'd3, 16'h0000, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset A: got %h expected %h", obs_vec(0), {4'd3, 4'd3, 16'h0000, 1'b1, 2'b00, 1'b0});
        end
        n_checks++;
        if ({p1_b, p2_b, hex_b, frz_b, win_b, ro_b} !== {4'd1, 4'd1, 16'h0000, 1'b1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset B: got %h expected %h", obs_vec(1), {4'd1, 4'd1, 16'h0000, 1'b1, 2'b00, 1'b0});
        end
        start_a = 1'b0; h1_a = 1'b0; h2_a = 1'b0;
        m_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_tally_saturate();
        for (int r = 1; r <= 101; r++) begin
            frame(0, 0, 0, 1, 0, 0);
            frame(0, 0, 0, 0, 0, 1);
            repeat (3) frame(0, 0, 0, 0, 0, 0);
            n_checks++;
            if (obs_vec(1) !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL tally round %0d: got %h expected %h", r, obs_vec(1), exp_vec(1));
            end
            if (r == 10) begin
                n_checks++;
                if (hex_b[15:8] !== 8'h10) begin
                    n_fail++;
                    $display("FAIL bcd_carry: got %h expected 10", hex_b[15:8]);
                end
            end
            if (r == 101) begin
                n_checks++;
                if (hex_b[15:8] !== 8'h99) begin
                    n_fail++;
                    $display("FAIL bcd_saturate: got %h expected 99", hex_b[15:8]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            frame(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random frame %0d inst%0d: got %h expected %h", i, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hold_hit();
        test_p2_out();
        test_draw();
        test_async_reset();
        test_tally_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
